// File: rtl/test_step_sequencer_if.sv
// Control bus driven by the step sequencer towards the datapath under test.
// master: the sequencer (drives every field); slave: the consumer (datapath/bench).
//   immediate     16b immediate operand
//   regEnables    5b  register write strobe (non-zero for one cycle per step)
//   buffAEnables  5b  one-hot A bus select
//   buffBEnables  5b  one-hot B bus select
//   Cin, regOrImmed, op[3:0], exop[3:0]  ALU controls
//   stepIdx       3b  current program step
//   done          1b  high at the final step
interface test_step_sequencer_if;
    logic [15:0] immediate;
    logic [4:0]  regEnables;
    logic [4:0]  buffAEnables;
    logic [4:0]  buffBEnables;
    logic        Cin;
    logic        regOrImmed;
    logic [3:0]  op;
    logic [3:0]  exop;
    logic [2:0]  stepIdx;
    logic        done;

    modport master (
        output immediate, regEnables, buffAEnables, buffBEnables,
        output Cin, regOrImmed, op, exop, stepIdx, done
    );
    modport slave (
        input immediate, regEnables, buffAEnables, buffBEnables,
        input Cin, regOrImmed, op, exop, stepIdx, done
    );
endinterface

// File: rtl/test_step_sequencer.sv
// Steps a fixed 8-row control program onto a datapath, either one step per
// debounced button press or one step per auto-run tick.
//   clk      system clock, rising edge
//   resetIN  asynchronous active-low reset
//   stepBtn  raw push-button (asynchronous, bouncy)
//   select   00 hold, 01 manual step, 10 auto-run, 11 restart
//   bus      control outputs (all registered)
module test_step_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_DIV        = 50000000
) (
    input  logic                          clk,
    input  logic                          resetIN,
    input  logic                          stepBtn,
    input  logic [1:0]                    select,
    test_step_sequencer_if.master         bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AD_W = $clog2(AUTO_DIV + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AD_W-1:0] AD_MAX = AD_W'(AUTO_DIV - 1);

    typedef enum logic [1:0] {INIT, STROBE, HOLD} state_t;

    typedef struct packed {
        logic [15:0] imm;
        logic [4:0]  reg_en;
        logic [4:0]  a_en;
        logic [4:0]  b_en;
        logic        roi;
        logic [3:0]  op;
        logic [3:0]  exop;
        logic        cin;
    } row_t;

    function automatic row_t row_lookup(input logic [2:0] i);
        row_t r;
        r = '0;
        case (i)
            3'd0: r = {16'h0005, 5'b00001, 5'b00000, 5'b00000, 1'b1, 4'h0, 4'h5, 1'b0};
            3'd1: r = {16'h0003, 5'b00010, 5'b00000, 5'b00000, 1'b1, 4'h0, 4'h5, 1'b0};
            3'd2: r = {16'h0000, 5'b00100, 5'b00001, 5'b00010, 1'b0, 4'h0, 4'h5, 1'b0};
            3'd3: r = {16'h0000, 5'b01000, 5'b00001, 5'b00010, 1'b0, 4'h0, 4'h9, 1'b0};
            3'd4: r = {16'h0000, 5'b10000, 5'b00001, 5'b00010, 1'b0, 4'h0, 4'h1, 1'b0};
            3'd5: r = {16'h0000, 5'b00001, 5'b00100, 5'b01000, 1'b0, 4'h0, 4'h2, 1'b0};
            3'd6: r = {16'h0000, 5'b00010, 5'b10000, 5'b00001, 1'b0, 4'h0, 4'h3, 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

    // ---------------- button path: sync -> debounce -> rising pulse
    logic            sync1, sync2;
    logic            db_level;
    logic [DB_W-1:0] db_cnt;
    logic            step_pulse;

    always_ff @(posedge clk or negedge resetIN) begin
        if (!resetIN) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            db_level   <= 1'b0;
            db_cnt     <= '0;
            step_pulse <= 1'b0;
        end else begin
            sync1      <= stepBtn;
            sync2      <= sync1;
            step_pulse <= 1'b0;
            // db_cnt counts consecutive samples that disagree with the
            // accepted level; any agreeing sample restarts the run.
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                db_level   <= sync2;
                db_cnt     <= '0;
                step_pulse <= sync2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // ---------------- auto-run divider
    logic [AD_W-1:0] auto_cnt;
    logic            tick;

    assign tick = (select == 2'b10) && (auto_cnt == AD_MAX);

    always_ff @(posedge clk or negedge resetIN) begin
        if (!resetIN)                auto_cnt <= '0;
        else if (select != 2'b10)    auto_cnt <= '0;
        else if (auto_cnt == AD_MAX) auto_cnt <= '0;
        else                         auto_cnt <= auto_cnt + 1'b1;
    end

    logic advance;
    assign advance = ((select == 2'b01) && step_pulse) || tick;

    // ---------------- step FSM
    state_t     state, state_n;
    logic [2:0] step_idx, idx_n;
    logic       load, clear;
    row_t       row_n;
    row_t       cur;       // currently loaded row (reg_en held separately)
    logic [4:0] reg_en_q;
    logic       done_q;

    always_comb begin
        state_n = state;
        idx_n   = step_idx;
        load    = 1'b0;
        clear   = 1'b0;
        if (select == 2'b11) begin
            // restart wins over any event in the same cycle
            state_n = INIT;
            idx_n   = 3'd0;
            clear   = 1'b1;
        end else begin
            case (state)
                INIT: begin
                    idx_n   = 3'd0;
                    load    = 1'b1;
                    state_n = STROBE;
                end
                STROBE: state_n = HOLD;   // events here are dropped
                HOLD: begin
                    if (advance && step_idx != 3'd7) begin
                        idx_n   = step_idx + 3'd1;
                        load    = 1'b1;
                        state_n = STROBE;
                    end
                end
                default: state_n = INIT;
            endcase
        end
    end

    assign row_n = row_lookup(idx_n);

    always_ff @(posedge clk or negedge resetIN) begin
        if (!resetIN) begin
            state    <= INIT;
            step_idx <= 3'd0;
            cur      <= '0;
            reg_en_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            step_idx <= idx_n;
            done_q   <= (idx_n == 3'd7);
            // every load enters STROBE, so the write strobe lives exactly one cycle
            reg_en_q <= load ? row_n.reg_en : 5'b00000;
            if (clear)     cur <= '0;
            else if (load) cur <= row_n;
        end
    end

    assign bus.immediate    = cur.imm;
    assign bus.regEnables   = reg_en_q;
    assign bus.buffAEnables = cur.a_en;
    assign bus.buffBEnables = cur.b_en;
    assign bus.Cin          = cur.cin;
    assign bus.regOrImmed   = cur.roi;
    assign bus.op           = cur.op;
    assign bus.exop         = cur.exop;
    assign bus.stepIdx      = step_idx;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_test_step_sequencer.sv
module tb_test_step_sequencer;
    localparam int DB = 4;
    localparam int AD = 10;

    logic       clk = 1'b0;
    logic       resetIN = 1'b0;
    logic       stepBtn = 1'b0;
    logic [1:0] select = 2'b01;

    int errors = 0;
    int checks = 0;

    test_step_sequencer_if bus ();

    test_step_sequencer #(.DEBOUNCE_CYCLES(DB), .AUTO_DIV(AD)) dut (
        .clk     (clk),
        .resetIN (resetIN),
        .stepBtn (stepBtn),
        .select  (select),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // observed outputs, laid out in table order followed by stepIdx, done
    wire [44:0] got = {bus.immediate, bus.regEnables, bus.buffAEnables, bus.buffBEnables,
                       bus.regOrImmed, bus.op, bus.exop, bus.Cin, bus.stepIdx, bus.done};

    // program table: {imm, regEn, A, B, regOrImmed, op, exop, Cin}
    function automatic logic [40:0] row_of(input int i);
        case (i)
            0: return {16'h0005, 5'b00001, 5'b00000, 5'b00000, 1'b1, 4'b0000, 4'b0101, 1'b0};
            1: return {16'h0003, 5'b00010, 5'b00000, 5'b00000, 1'b1, 4'b0000, 4'b0101, 1'b0};
            2: return {16'h0000, 5'b00100, 5'b00001, 5'b00010, 1'b0, 4'b0000, 4'b0101, 1'b0};
            3: return {16'h0000, 5'b01000, 5'b00001, 5'b00010, 1'b0, 4'b0000, 4'b1001, 1'b0};
            4: return {16'h0000, 5'b10000, 5'b00001, 5'b00010, 1'b0, 4'b0000, 4'b0001, 1'b0};
            5: return {16'h0000, 5'b00001, 5'b00100, 5'b01000, 1'b0, 4'b0000, 4'b0010, 1'b0};
            6: return {16'h0000, 5'b00010, 5'b10000, 5'b00001, 1'b0, 4'b0000, 4'b0011, 1'b0};
            default: return '0;
        endcase
    endfunction

    // ---------------- reference model
    // Button: raw history queue, synchronizer = 2-sample delay, debouncer =
    // "last DB samples all differ from accepted level". Auto tick: count of
    // consecutive prior cycles spent in auto mode, modulo AD.
    bit          rawq[$];
    bit          sq[$];
    bit          m_level = 0;
    bit          m_pulse = 0;
    int          m_run = 0;
    int          m_idx = 0;
    int          m_phase = 0;      // 0 idle/init, 1 strobing, 2 holding
    logic [40:0] m_ld = '0;

    task automatic model_reset();
        rawq = '{1'b0, 1'b0};
        sq.delete();
        m_level = 0; m_pulse = 0; m_run = 0;
        m_idx = 0; m_phase = 0; m_ld = '0;
    endtask

    task automatic model_step();
        bit s, tick, adv, newp, all_diff;
        rawq.push_back(stepBtn);
        s = rawq[rawq.size()-3];
        if (rawq.size() > 3) void'(rawq.pop_front());
        sq.push_back(s);
        if (sq.size() > DB) void'(sq.pop_front());
        newp = 0;
        if (sq.size() == DB) begin
            all_diff = 1;
            foreach (sq[i]) if (sq[i] == m_level) all_diff = 0;
            if (all_diff) begin
                m_level = ~m_level;
                newp = m_level;
            end
        end
        tick  = (select == 2'b10) && ((m_run % AD) == AD - 1);
        m_run = (select == 2'b10) ? m_run + 1 : 0;
        adv   = ((select == 2'b01) && m_pulse) || tick;
        m_pulse = newp;
        if (select == 2'b11) begin
            m_idx = 0; m_phase = 0; m_ld = '0;
        end else if (m_phase == 0) begin
            m_idx = 0; m_ld = row_of(0); m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (adv && m_idx < 7) begin
            m_idx++; m_ld = row_of(m_idx); m_phase = 1;
        end
    endtask

    always @(posedge clk or negedge resetIN) begin
        if (!resetIN) model_reset();
        else          model_step();
    end

    function automatic logic [44:0] exp_vec();
        logic [40:0] r;
        r = m_ld;
        if (m_phase != 1) r[24:20] = 5'b00000;
        return {r, 3'(m_idx), (m_idx == 7)};
    endfunction

    // ---------------- scenarios
    task automatic test_reset();
        resetIN = 1'b0; select = 2'b01; stepBtn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (got !== 45'd0) begin
            errors++; $display("FAIL reset_zero got=%h exp=0", got);
        end
        resetIN = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.immediate !== 16'h0005 || bus.regEnables !== 5'b00001) begin
            errors++; $display("FAIL first_strobe imm=%h reg=%b exp imm=0005 reg=00001",
                               bus.immediate, bus.regEnables);
        end
        @(negedge clk);
        checks++;
        if (bus.immediate !== 16'h0005 || bus.regEnables !== 5'b00000 || got !== exp_vec()) begin
            errors++; $display("FAIL strobe_end got=%h exp=%h", got, exp_vec());
        end
    endtask

    task automatic test_debounce();
        int strobes = 0;
        logic [15:0] s_imm = '0;
        logic [4:0]  s_reg = '0;
        logic [2:0]  pattern = 3'b101;
        for (int c = 0; c < 15; c++) begin
            stepBtn = (c < 3) ? pattern[2-c] : 1'b1;
            @(negedge clk);
            checks++;
            if (got !== exp_vec()) begin
                errors++; $display("FAIL debounce_cycle%0d got=%h exp=%h", c, got, exp_vec());
            end
            if (bus.regEnables != 5'b0) begin
                strobes++; s_imm = bus.immediate; s_reg = bus.regEnables;
            end
        end
        checks++;
        if (strobes != 1 || s_imm !== 16'h0003 || s_reg !== 5'b00010 || bus.stepIdx !== 3'd1) begin
            errors++; $display("FAIL debounce_one_step strobes=%0d imm=%h reg=%b idx=%0d exp 1/0003/00010/1",
                               strobes, s_imm, s_reg, bus.stepIdx);
        end
        stepBtn = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.stepIdx !== 3'd1 || got !== exp_vec()) begin
            errors++; $display("FAIL release_no_step idx=%0d exp=1", bus.stepIdx);
        end
    endtask

    task automatic test_auto_run();
        int last = -1, strobes = 0, advs = 0;
        logic [2:0] prev;
        prev = bus.stepIdx;
        select = 2'b10;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            checks++;
            if (got !== exp_vec()) begin
                errors++; $display("FAIL auto_cycle%0d got=%h exp=%h", c, got, exp_vec());
            end
            if (bus.regEnables != 5'b0) strobes++;
            if (bus.stepIdx != prev) begin
                advs++;
                if (last >= 0) begin
                    checks++;
                    if (c - last != AD) begin
                        errors++; $display("FAIL auto_period got=%0d exp=%0d", c - last, AD);
                    end
                end
                last = c; prev = bus.stepIdx;
            end
        end
        checks++;
        if (bus.stepIdx !== 3'd7 || bus.done !== 1'b1 || advs != 6 || strobes != 5) begin
            errors++; $display("FAIL auto_saturate idx=%0d done=%b advs=%0d strobes=%0d exp 7/1/6/5",
                               bus.stepIdx, bus.done, advs, strobes);
        end
    endtask

    task automatic test_restart();
        select = 2'b11;
        @(negedge clk);
        checks++;
        if (got !== 45'd0) begin
            errors++; $display("FAIL restart_clear got=%h exp=0", got);
        end
        select = 2'b10;
        for (int c = 0; c < 59; c++) begin
            @(negedge clk);
            checks++;
            if (got !== exp_vec()) begin
                errors++; $display("FAIL restart_run%0d got=%h exp=%h", c, got, exp_vec());
            end
        end
        checks++;
        if (bus.stepIdx !== 3'd5) begin
            errors++; $display("FAIL pre_restart_idx got=%0d exp=5", bus.stepIdx);
        end
        // divider is at its last count here: this edge would have ticked
        select = 2'b11;
        @(negedge clk);
        checks++;
        if (got !== 45'd0 || got !== exp_vec()) begin
            errors++; $display("FAIL restart_at_idx5 got=%h exp=0", got);
        end
        select = 2'b01;
        @(negedge clk);
        checks++;
        if (bus.immediate !== 16'h0005 || bus.regEnables !== 5'b00001 || bus.stepIdx !== 3'd0) begin
            errors++; $display("FAIL restart_row0 imm=%h reg=%b idx=%0d exp 0005/00001/0",
                               bus.immediate, bus.regEnables, bus.stepIdx);
        end
    endtask

    task automatic test_reset_mid_strobe();
        bit found = 0;
        select = 2'b10;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (bus.regEnables == 5'b01000 && bus.stepIdx == 3'd3) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL step3_strobe_timeout reg=%b idx=%0d exp 01000/3",
                               bus.regEnables, bus.stepIdx);
        end
        resetIN = 1'b0;
        #1;
        checks++;
        if (got !== 45'd0) begin
            errors++; $display("FAIL mid_strobe_reset got=%h exp=0", got);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.regEnables !== 5'b0 || got !== exp_vec()) begin
                errors++; $display("FAIL reset_hold%0d got=%h exp=%h", c, got, exp_vec());
            end
        end
        resetIN = 1'b1;
    endtask

    task automatic test_random();
        int r;
        select = 2'b01;
        stepBtn = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                r = $urandom_range(0, 19);
                select = (r < 8) ? 2'b01 : (r < 16) ? 2'b10 : (r < 19) ? 2'b00 : 2'b11;
            end
            if ($urandom_range(0, 7) == 0) stepBtn = ~stepBtn;
            @(negedge clk);
            checks++;
            if (got !== exp_vec()) begin
                errors++; $display("FAIL random_cycle%0d got=%h exp=%h sel=%b", c, got, exp_vec(), select);
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_auto_run();
        test_restart();
        test_reset_mid_strobe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
